man_coord_gen: RTL

Pixel coordinate generator for the Mandelbrot engine. It sits directly downstream of the control block's register interface and consumes `man_init`, `man_x0`, `man_y0`, `man_xs` and `man_ys`. On each init it walks an HRES×VRES raster and issues one fixed-point (x, y) coordinate plus a linear pixel address per handshake to the iteration engines. It reports frame completion back on `man_done`.

---
 rtl/man_coord_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/man_coord_gen.sv
// Raster coordinate generator: walks an HRES x VRES frame and issues one (x, y, address) per handshake.
// Optional MAN_COORD_GEN_EOL_EN adds the registered end-of-line flag out_eol.
module man_coord_gen #(
    parameter int unsigned FPW  = 54,
    parameter int unsigned HRES = 800,
    parameter int unsigned VRES = 600,
    parameter int unsigned AW   = 19
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           man_init,
    output logic           man_done,
    input  logic [FPW-1:0] man_x0,
    input  logic [FPW-1:0] man_y0,
    input  logic [FPW-1:0] man_xs,
    input  logic [FPW-1:0] man_ys,
    output logic           busy,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [FPW-1:0] out_x,
    output logic [FPW-1:0] out_y,
    output logic [AW-1:0]  out_adr
`ifdef MAN_COORD_GEN_EOL_EN
    ,
    output logic           out_eol
`endif
);

    localparam int unsigned IW = (HRES > 1) ? $clog2(HRES) : 1;
    localparam int unsigned JW = (VRES > 1) ? $clog2(VRES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [FPW-1:0] x0_q, x0_d, xs_q, xs_d, ys_q, ys_d;
    logic [FPW-1:0] x_q, x_d, y_q, y_d;
    logic [AW-1:0]  adr_q, adr_d;
    logic [IW-1:0]  i_q, i_d;
    logic [JW-1:0]  j_q, j_d;
    logic           vld_q, vld_d, done_q, done_d, busy_q, busy_d;
`ifdef MAN_COORD_GEN_EOL_EN
    logic           eol_q, eol_d;
`endif

    logic accept_c, last_col_c, last_row_c;

    assign accept_c   = vld_q & out_rdy;
    assign last_col_c = (i_q == IW'(HRES - 1));
    assign last_row_c = (j_q == JW'(VRES - 1));

    // Next-state: init wins over everything, including a same-cycle accept.
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        x_d     = x_q;
        y_d     = y_q;
        adr_d   = adr_q;
        i_d     = i_q;
        j_d     = j_q;
        vld_d   = vld_q;
        done_d  = done_q;
        busy_d  = busy_q;
`ifdef MAN_COORD_GEN_EOL_EN
        eol_d   = eol_q;
`endif
        if (man_init) begin
            state_d = RUN;
            x0_d    = man_x0;
            xs_d    = man_xs;
            ys_d    = man_ys;
            x_d     = man_x0;
            y_d     = man_y0;
            adr_d   = '0;
            i_d     = '0;
            j_d     = '0;
            vld_d   = 1'b1;
            done_d  = 1'b0;
            busy_d  = 1'b1;
`ifdef MAN_COORD_GEN_EOL_EN
            eol_d   = (HRES == 1);
`endif
        end else begin
            case (state_q)
                RUN: begin
                    if (accept_c) begin
                        if (last_col_c && last_row_c) begin
                            state_d = DONE;
                            vld_d   = 1'b0;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
`ifdef MAN_COORD_GEN_EOL_EN
                            eol_d   = 1'b0;
`endif
                        end else if (last_col_c) begin
                            i_d   = '0;
                            j_d   = j_q + JW'(1);
                            x_d   = x0_q;
                            y_d   = y_q + ys_q;
                            adr_d = adr_q + AW'(1);
`ifdef MAN_COORD_GEN_EOL_EN
                            eol_d = (HRES == 1);
`endif
                        end else begin
                            i_d   = i_q + IW'(1);
                            x_d   = x_q + xs_q;
                            adr_d = adr_q + AW'(1);
`ifdef MAN_COORD_GEN_EOL_EN
                            eol_d = ((i_q + IW'(1)) == IW'(HRES - 1));
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x0_q    <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            adr_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MAN_COORD_GEN_EOL_EN
            eol_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            x_q     <= x_d;
            y_q     <= y_d;
            adr_q   <= adr_d;
            i_q     <= i_d;
            j_q     <= j_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef MAN_COORD_GEN_EOL_EN
            eol_q   <= eol_d;
`endif
        end
    end

    assign man_done = done_q;
    assign busy     = busy_q;
    assign out_vld  = vld_q;
    assign out_x    = x_q;
    assign out_y    = y_q;
    assign out_adr  = adr_q;
`ifdef MAN_COORD_GEN_EOL_EN
    assign out_eol  = eol_q;
`endif

endmodule
